// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter slice.
// Pending-response tag plus port identifiers used as grant-vector indices.
package imem_arb_pkg;

  localparam int AW_DEF = 7;
  localparam int DW_DEF = 32;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic err;
  } pend_tag_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational two-requester winner select returning a one-hot grant.
// prio1_i decides contention only; a lone requester always wins.
module imem_arb_pick
  import imem_arb_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       prio1_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i) begin
      gnt_o[PORT_LOAD]  = prio1_i;
      gnt_o[PORT_FETCH] = ~prio1_i;
    end else if (req0_i) begin
      gnt_o[PORT_FETCH] = 1'b1;
    end else if (req1_i) begin
      gnt_o[PORT_LOAD] = 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Fetch/loader arbiter in front of a single-port registered instruction memory.
// Build option IMEM_ARB_RR_EN: round-robin on contention instead of fetch priority + aging.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("imem_arbiter: MAX_WAIT must be within 1..15");
  end

  logic [1:0]    gnt;
  logic          prio1;
  logic          any_gnt;
  logic          aligned;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  pend_tag_t     pend_q, pend_d;
  logic          rsp_live;

  // Reset masks requests so nothing is granted while rst is high.
  imem_arb_pick u_pick (
    .req0_i  (p0_req & ~rst),
    .req1_i  (p1_req & ~rst),
    .prio1_i (prio1),
    .gnt_o   (gnt)
  );

  assign p0_gnt    = gnt[PORT_FETCH];
  assign p1_gnt    = gnt[PORT_LOAD];
  assign any_gnt   = |gnt;
  assign win_we    = gnt[PORT_LOAD] ? p1_we    : p0_we;
  assign win_addr  = gnt[PORT_LOAD] ? p1_addr  : p0_addr;
  assign win_wdata = gnt[PORT_LOAD] ? p1_wdata : p0_wdata;
  assign aligned   = is_aligned(win_addr[1:0]);

  assign mem_read  = any_gnt & ~win_we & aligned;
  assign mem_write = any_gnt &  win_we & aligned;

  assign addr_d    = any_gnt ? win_addr  : addr_q;
  assign wdata_d   = any_gnt ? win_wdata : wdata_q;
  assign mem_addr  = rst ? '0 : addr_d;
  assign mem_wdata = rst ? '0 : wdata_d;

  // Misaligned accesses of either direction still owe the owner an error response.
  always_comb begin
    pend_d       = '0;
    pend_d.valid = any_gnt & (~win_we | ~aligned);
    pend_d.owner = gnt[PORT_LOAD];
    pend_d.err   = ~aligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rsp_live  = pend_q.valid & ~rst;
  assign p0_rvalid = rsp_live & (pend_q.owner == PORT_FETCH);
  assign p1_rvalid = rsp_live & (pend_q.owner == PORT_LOAD);
  assign p0_err    = p0_rvalid & pend_q.err;
  assign p1_err    = p1_rvalid & pend_q.err;
  assign p0_rdata  = (p0_rvalid & ~pend_q.err) ? mem_rdata : '0;
  assign p1_rdata  = (p1_rvalid & ~pend_q.err) ? mem_rdata : '0;

`ifdef IMEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // Reset value of PORT_LOAD hands the first contention to fetch.
  assign prio1        = (last_owner_q == PORT_FETCH);
  assign last_owner_d = any_gnt ? gnt[PORT_LOAD] : last_owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= PORT_LOAD;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] age_q, age_d;

  assign prio1 = (age_q == MAX_W);

  // Counts consecutive losses of a waiting loader; any break in the wait clears it.
  always_comb begin
    age_d = '0;
    if (p1_req && !gnt[PORT_LOAD]) begin
      age_d = (age_q == MAX_W) ? age_q : age_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model with its own memory image.
module tb_imem_arbiter;

  localparam int AW       = 7;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] words [3];

  always #5 clk = ~clk;

  imem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port memory: registered read, zero output when not read, write stored.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    mem_rdata <= '0;
    if (mem_read)  mem_rdata <= mem[mem_addr[AW-1:2]];
    if (mem_write) mem[mem_addr[AW-1:2]] <= mem_wdata;
  end

  task automatic idle();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    p0_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      checks++; if (p0_gnt !== 1'b0) begin errors++; $display("FAIL reset_p0_gnt got %0b want 0", p0_gnt); end
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %0b%0b want 00", mem_read, mem_write); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
      checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b%0b want 00", p0_rvalid, p1_rvalid); end
    end
    rst = 1'b0;
    #1;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL release_p0_gnt got %0b want 1", p0_gnt); end
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL release_mem_read got %0b want 1", mem_read); end
    checks++; if (mem_addr !== 7'h00) begin errors++; $display("FAIL release_mem_addr got %h want 00", mem_addr); end
  endtask

  task automatic test_back_to_back();
    words[0] = 32'h00700813; words[1] = 32'h00002217; words[2] = 32'hFFC20213;
    for (int i = 0; i < 3; i++) begin
      cyc();
      idle();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = AW'(i * 4); p0_wdata = words[i];
      #1;
      checks++; if (p0_gnt !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL b2b_load%0d got gnt=%0b wr=%0b want 1 1", i, p0_gnt, mem_write); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      idle();
      if (i < 3) begin p0_req = 1'b1; p0_addr = AW'(i * 4); end
      #1;
      if (i < 3) begin
        checks++; if (p0_gnt !== 1'b1 || mem_read !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d got gnt=%0b rd=%0b want 1 1", i, p0_gnt, mem_read); end
      end
      if (i == 0) begin
        checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_write_rvalid got %0b want 0", p0_rvalid); end
      end else begin
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== words[i-1]) begin errors++; $display("FAIL b2b_rdata%0d got v=%0b %h want 1 %h", i, p0_rvalid, p0_rdata, words[i-1]); end
        checks++; if (p1_rvalid !== 1'b0 || p1_rdata !== '0) begin errors++; $display("FAIL b2b_nonowner got v=%0b %h want 0 0", p1_rvalid, p1_rdata); end
      end
    end
  endtask

  task automatic test_contention();
    int  prev;
    logic exp1;
    cyc(); idle(); rst = 1'b1;
    cyc(); rst = 1'b0;
    p0_req = 1'b1; p0_addr = 7'h00;
    p1_req = 1'b1; p1_addr = 7'h04;
    prev = -1;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) cyc();
      #1;
`ifdef IMEM_ARB_RR_EN
      exp1 = (k % 2) == 1;
`else
      exp1 = (k % (MAX_WAIT + 1)) == MAX_WAIT;
`endif
      checks++; if (p1_gnt !== exp1 || p0_gnt !== !exp1) begin errors++; $display("FAIL contend_k%0d got p0=%0b p1=%0b want p1=%0b", k, p0_gnt, p1_gnt, exp1); end
      if (prev >= 0) begin
        checks++; if (p1_rvalid !== (prev == 1) || p0_rvalid !== (prev == 0)) begin errors++; $display("FAIL contend_rvalid_k%0d got %0b%0b prev=%0d", k, p0_rvalid, p1_rvalid, prev); end
        if (prev == 1) begin
          checks++; if (p1_rdata !== words[1]) begin errors++; $display("FAIL contend_p1_rdata got %h want %h", p1_rdata, words[1]); end
        end
      end
      prev = exp1 ? 1 : 0;
    end
    cyc(); idle();
  endtask

  task automatic test_write_read();
    cyc(); idle();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 7'h48; p1_wdata = 32'h12345678;
    #1;
    checks++; if (p1_gnt !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL wr_drive got gnt=%0b wr=%0b rd=%0b want 1 1 0", p1_gnt, mem_write, mem_read); end
    checks++; if (mem_addr !== 7'h48 || mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_bus got %h %h want 48 12345678", mem_addr, mem_wdata); end
    cyc(); idle();
    p1_req = 1'b1; p1_addr = 7'h48;
    #1;
    checks++; if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %0b want 0", p1_rvalid); end
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL rd_drive got rd=%0b wr=%0b want 1 0", mem_read, mem_write); end
    cyc(); idle();
    #1;
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h12345678 || p1_err !== 1'b0) begin errors++; $display("FAIL rd_back got v=%0b e=%0b %h want 1 0 12345678", p1_rvalid, p1_err, p1_rdata); end
    checks++; if (mem_addr !== 7'h48 || mem_read !== 1'b0) begin errors++; $display("FAIL idle_hold got addr=%h rd=%0b want 48 0", mem_addr, mem_read); end
  endtask

  task automatic test_misaligned();
    cyc(); idle();
    p0_req = 1'b1; p0_addr = 7'h05;
    #1;
    checks++; if (p0_gnt !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL mis_rd_drive got gnt=%0b rd=%0b wr=%0b want 1 0 0", p0_gnt, mem_read, mem_write); end
    cyc(); idle();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 7'h4A; p1_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (p0_rvalid !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== '0) begin errors++; $display("FAIL mis_rd_rsp got v=%0b e=%0b %h want 1 1 0", p0_rvalid, p0_err, p0_rdata); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL mis_wr_drive got wr=%0b want 0", mem_write); end
    cyc(); idle();
    #1;
    checks++; if (p1_rvalid !== 1'b1 || p1_err !== 1'b1 || p1_rdata !== '0) begin errors++; $display("FAIL mis_wr_rsp got v=%0b e=%0b %h want 1 1 0", p1_rvalid, p1_err, p1_rdata); end
  endtask

  task automatic test_reset_mid();
    cyc(); idle();
    p1_req = 1'b1; p1_addr = 7'h04;
    #1;
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %0b want 1", p1_gnt); end
    cyc(); idle(); rst = 1'b1;
    #1;
    checks++; if (p1_rvalid !== 1'b0 || p1_rdata !== '0) begin errors++; $display("FAIL rstmid_rvalid got %0b %h want 0 0", p1_rvalid, p1_rdata); end
    cyc(); rst = 1'b0;
    #1;
    checks++; if (p1_rvalid !== 1'b0 || p0_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_after got %0b%0b want 00", p0_rvalid, p1_rvalid); end
  endtask

  task automatic test_random();
    logic          act [2];
    logic          we  [2];
    logic [AW-1:0] ad  [2];
    logic [DW-1:0] wd  [2];
    logic [DW-1:0] shadow [32];
    logic          ev  [2];
    logic          ee  [2];
    logic [DW-1:0] ed  [2];
    logic          ok, exp_rd, exp_wr, rv, er;
    logic [DW-1:0] rd;
    int            waited, last, w;

    cyc(); idle(); rst = 1'b1;
    cyc(); rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) cyc();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = AW'(i * 4); p0_wdata = $urandom;
      shadow[i] = p0_wdata;
      #1;
      checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL rnd_init%0d got %0b want 1", i, p0_gnt); end
    end
    cyc(); idle();
    for (int p = 0; p < 2; p++) begin act[p] = 1'b0; ev[p] = 1'b0; ee[p] = 1'b0; ed[p] = '0; end
    waited = 0;
    last   = 0;
    ok     = 1'b0;

    for (int n = 0; n < 400; n++) begin
      cyc();
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 99) < 65) begin
          act[p] = 1'b1;
          we[p]  = ($urandom_range(0, 3) == 0);
          ad[p]  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : {5'($urandom), 2'b00};
          wd[p]  = $urandom;
        end
      end
      p0_req = act[0]; p0_we = we[0]; p0_addr = ad[0]; p0_wdata = wd[0];
      p1_req = act[1]; p1_we = we[1]; p1_addr = ad[1]; p1_wdata = wd[1];
      #1;

      if (act[0] && act[1]) begin
`ifdef IMEM_ARB_RR_EN
        w = (last == 0) ? 1 : 0;
`else
        w = (waited >= MAX_WAIT) ? 1 : 0;
`endif
      end else if (act[0]) w = 0;
      else if (act[1]) w = 1;
      else w = -1;

      exp_rd = 1'b0; exp_wr = 1'b0;
      if (w >= 0) begin
        ok     = (ad[w][1:0] == 2'b00);
        exp_rd = ok && !we[w];
        exp_wr = ok && we[w];
      end

      checks++; if (p0_gnt !== (w == 0) || p1_gnt !== (w == 1)) begin errors++; $display("FAIL rnd_gnt n=%0d got %0b%0b want winner %0d", n, p0_gnt, p1_gnt, w); end
      checks++; if (mem_read !== exp_rd || mem_write !== exp_wr) begin errors++; $display("FAIL rnd_en n=%0d got rd=%0b wr=%0b want %0b %0b", n, mem_read, mem_write, exp_rd, exp_wr); end
      if (w >= 0) begin
        checks++; if (mem_addr !== ad[w]) begin errors++; $display("FAIL rnd_addr n=%0d got %h want %h", n, mem_addr, ad[w]); end
      end
      if (exp_wr) begin
        checks++; if (mem_wdata !== wd[w]) begin errors++; $display("FAIL rnd_wdata n=%0d got %h want %h", n, mem_wdata, wd[w]); end
      end
      for (int p = 0; p < 2; p++) begin
        rv = p ? p1_rvalid : p0_rvalid;
        er = p ? p1_err    : p0_err;
        rd = p ? p1_rdata  : p0_rdata;
        checks++;
        if (rv !== ev[p] || er !== (ev[p] & ee[p]) || rd !== ((ev[p] && !ee[p]) ? ed[p] : '0)) begin
          errors++;
          $display("FAIL rnd_rsp n=%0d port%0d got v=%0b e=%0b %h want v=%0b e=%0b %h", n, p, rv, er, rd, ev[p], ev[p] & ee[p], (ev[p] && !ee[p]) ? ed[p] : '0);
        end
      end

      ev[0] = 1'b0; ev[1] = 1'b0;
      if (w >= 0) begin
        if (!ok || !we[w]) begin
          ev[w] = 1'b1;
          ee[w] = !ok;
          ed[w] = ok ? shadow[ad[w][AW-1:2]] : '0;
        end
        if (ok && we[w]) shadow[ad[w][AW-1:2]] = wd[w];
        waited = (w == 0 && act[1]) ? ((waited < MAX_WAIT) ? waited + 1 : MAX_WAIT) : 0;
        last   = w;
        act[w] = 1'b0;
      end else begin
        waited = 0;
      end
    end
    cyc(); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_back_to_back();
    test_contention();
    test_write_read();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
